// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper.
//   state_t      : sweep FSM states (IDLE, DRIVE, CHECK, FINISH)
//   STATE_W      : state register width
//   SETTLE_CNT_W : width of the settle down-counter (SETTLE is 0..15)
package tt_sweep_pkg;

  localparam int unsigned STATE_W      = 2;
  localparam int unsigned SETTLE_CNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable settle down-counter used while a vector is being held.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : load LOAD_VAL (takes priority over en)
//   en         : decrement, saturating at zero
//   zero       : count is zero
module tt_settle_cnt
  import tt_sweep_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [SETTLE_CNT_W-1:0] LOAD_W = SETTLE_CNT_W'(LOAD_VAL);

  logic [SETTLE_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_W;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - SETTLE_CNT_W'(1);
    end
  end

  always_comb zero = (cnt == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper/checker for small combinational blocks.
// Drives dut_in = 0 .. 2**N_IN-1 in order, holds each vector SETTLE+1
// cycles, and compares dut_out against a truth table latched at start.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   start            : begin a sweep (honoured only in IDLE)
//   expected_tt      : expected outputs, vector v at [v*N_OUT +: N_OUT]
//   dut_in / dut_out : stimulus to / response from the block under check
//   busy             : sweep in progress (start accept .. FINISH exit)
//   done             : one-cycle end-of-sweep pulse
//   pass             : last sweep had no mismatches
//   err_count        : mismatching vectors in last sweep
//   first_fail_valid : at least one mismatch recorded
//   first_fail_vec   : lowest failing vector
// Optional feature: define TT_STOP_ON_FAIL_EN to end the sweep at the
// first mismatch.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [N_OUT*(2**N_IN)-1:0]  expected_tt,
  output logic [N_IN-1:0]             dut_in,
  input  logic [N_OUT-1:0]            dut_out,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [N_IN:0]               err_count,
  output logic                        first_fail_valid,
  output logic [N_IN-1:0]             first_fail_vec
);

  localparam int unsigned TT_W = N_OUT * (2**N_IN);

  state_t            state;
  logic [TT_W-1:0]   tt_q;
  logic              mismatch;
  logic              last_vec;
  logic              go_finish;
  logic              cnt_load;
  logic              cnt_zero;

  // DRIVE lasts SETTLE cycles, so the counter starts at SETTLE-1 and
  // DRIVE exits on the cycle it reads zero.
  tt_settle_cnt #(
    .LOAD_VAL ((SETTLE > 0) ? SETTLE - 1 : 0)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .en    (state == DRIVE),
    .zero  (cnt_zero)
  );

  always_comb begin
    mismatch = (dut_out !== tt_q[dut_in*N_OUT +: N_OUT]);
    last_vec = (dut_in == '1);
`ifdef TT_STOP_ON_FAIL_EN
    go_finish = last_vec || mismatch;
`else
    go_finish = last_vec;
`endif
    cnt_load = ((state == IDLE) && start) || ((state == CHECK) && !go_finish);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      tt_q             <= '0;
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tt_q             <= expected_tt;
            dut_in           <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            pass             <= 1'b0;
            busy             <= 1'b1;
            state            <= (SETTLE > 0) ? DRIVE : CHECK;
          end
        end
        DRIVE: begin
          if (cnt_zero) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + (N_IN+1)'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= dut_in;
            end
          end
          if (go_finish) begin
            // done/pass are registered on FINISH entry so they appear
            // exactly 2**N_IN*(SETTLE+1) cycles after start accept.
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
            state <= FINISH;
          end else begin
            dut_in <= dut_in + N_IN'(1);
            state  <= (SETTLE > 0) ? DRIVE : CHECK;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
